// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared state encoding, tick constant and sizing helpers for button conditioning
package button_conditioner_pkg;

    localparam int MS_TICK_HZ = 1000;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

    // Clocks per 1 ms tick; a clock slower than 1 kHz still gets a tick every cycle.
    function automatic int calc_tick_div(input int clk_hz);
        int div;
        div = clk_hz / MS_TICK_HZ;
        return (div >= 1) ? div : 1;
    endfunction

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: 2-FF synchroniser, debounce FSM, hold counter and pulse outputs
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEB_MS  = 10,
    parameter int LONG_MS = 1000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic tick,
    input  logic raw_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DEB_W  = cnt_width(DEB_MS);
    localparam int LONG_W = cnt_width(LONG_MS);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_MS - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_MS);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MS - 1);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    btn_state_e        state_q, state_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [LONG_W-1:0] hold_q, hold_d;
    logic              armed_q, armed_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              pressed;

    assign pressed = ~sync2_q;

    always_comb begin
        sync1_d   = raw_n;
        sync2_d   = sync1_q;
        state_d   = state_q;
        deb_d     = deb_q;
        hold_d    = hold_q;
        armed_d   = armed_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        unique case (state_q)
            ST_RELEASED: begin
                level_d = 1'b0;
                if (pressed) begin
                    state_d = ST_PRESS_WAIT;
                    deb_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = ST_RELEASED;
                    deb_d   = '0;
                end else if (tick) begin
                    if (deb_q == DEB_LAST) begin
                        state_d = ST_HELD;
                        deb_d   = '0;
                        hold_d  = '0;
                        armed_d = 1'b1;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end
            end
            ST_HELD: begin
                if (!pressed) begin
                    state_d = ST_RELEASE_WAIT;
                    deb_d   = '0;
                end else if (tick && (hold_q != LONG_MAX)) begin
                    hold_d = hold_q + LONG_W'(1);
                    // Armed flag keeps the long pulse to one per accepted press.
                    if ((hold_q == LONG_LAST) && armed_q) begin
                        long_d  = 1'b1;
                        armed_d = 1'b0;
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = ST_HELD;
                    deb_d   = '0;
                end else if (tick) begin
                    if (deb_q == DEB_LAST) begin
                        state_d   = ST_RELEASED;
                        deb_d     = '0;
                        armed_d   = 1'b0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_RELEASED;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= ST_RELEASED;
            deb_q     <= '0;
            hold_q    <= '0;
            armed_q   <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            deb_q     <= deb_d;
            hold_q    <= hold_d;
            armed_q   <= armed_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - shared 1 ms tick divider feeding N independent debounce channels
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N       = 2,
    parameter int CLK_HZ  = 50_000_000,
    parameter int DEB_MS  = 10,
    parameter int LONG_MS = 1000
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [N-1:0] btn_n,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic [N-1:0] btn_long
);

    localparam int TICK_DIV = calc_tick_div(CLK_HZ);
    localparam int DIV_W    = cnt_width(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    // With a divide of one the counter stays at zero, so tick is high every cycle.
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_chan
        debounce_channel #(
            .DEB_MS  (DEB_MS),
            .LONG_MS (LONG_MS)
        ) u_chan (
            .Clk           (Clk),
            .Reset         (Reset),
            .tick          (tick),
            .raw_n         (btn_n[g]),
            .level         (btn_level[g]),
            .press_pulse   (btn_press[g]),
            .release_pulse (btn_release[g]),
            .long_pulse    (btn_long[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - table, directed and randomized checks of button_conditioner against a run-length model
module tb_button_conditioner;

    localparam int N       = 2;
    localparam int CLK_HZ  = 1000;
    localparam int DEB_MS  = 4;
    localparam int LONG_MS = 10;

    logic         Clk;
    logic         Reset;
    logic [N-1:0] btn_n;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_long;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    button_conditioner #(
        .N       (N),
        .CLK_HZ  (CLK_HZ),
        .DEB_MS  (DEB_MS),
        .LONG_MS (LONG_MS)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .btn_n       (btn_n),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: pressed level seen two edges late; a change is accepted after
    // DEB_MS+1 consecutive disagreeing edges; hold edges counted while pressed.
    logic [N-1:0] hist1, hist2, p_prev;
    logic [N-1:0] m_level, m_press, m_rel, m_long;
    int           run  [N];
    int           hold [N];

    task automatic model_reset();
        hist1 = '0; hist2 = '0; p_prev = '0;
        m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
        for (int c = 0; c < N; c++) begin
            run[c]  = 0;
            hold[c] = 0;
        end
    endtask

    task automatic model_edge(input logic [N-1:0] raw);
        logic p;
        for (int c = 0; c < N; c++) begin
            p = hist2[c];
            hist2[c] = hist1[c];
            hist1[c] = ~raw[c];
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            m_long[c]  = 1'b0;
            if (m_level[c] && p && p_prev[c] && hold[c] < LONG_MS) begin
                hold[c]++;
                if (hold[c] == LONG_MS) m_long[c] = 1'b1;
            end
            if (p != m_level[c]) begin
                run[c]++;
                if (run[c] == DEB_MS + 1) begin
                    m_level[c] = p;
                    run[c] = 0;
                    if (p) begin
                        m_press[c] = 1'b1;
                        hold[c] = 0;
                    end else begin
                        m_rel[c] = 1'b1;
                    end
                end
            end else begin
                run[c] = 0;
            end
            p_prev[c] = p;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    task automatic step();
        logic [N-1:0] raw;
        raw = btn_n;
        @(posedge Clk);
        cycle++;
        if (Reset) model_reset();
        else       model_edge(raw);
        #1;
        check("model outputs {level,press,release,long}",
              {24'd0, btn_level, btn_press, btn_release, btn_long},
              {24'd0, m_level, m_press, m_rel, m_long});
    endtask

    typedef struct {
        logic [1:0] btn_n;
        int         cycles;
        logic [1:0] exp_level;
        int         p0, p1, r0, r1, l0, l1;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int pc [N];
        int rc [N];
        int lc [N];
        int first_a, first_b, first_c;
        int remain [N];
        logic [N-1:0] pvec;

        tbl[0]  = '{2'b11, 20, 2'b00, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{2'b10,  8, 2'b01, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{2'b10, 20, 2'b01, 0, 0, 0, 0, 1, 0};
        tbl[3]  = '{2'b11,  8, 2'b00, 0, 0, 1, 0, 0, 0};
        tbl[4]  = '{2'b00,  8, 2'b11, 1, 1, 0, 0, 0, 0};
        tbl[5]  = '{2'b10,  8, 2'b01, 0, 0, 0, 1, 0, 0};
        tbl[6]  = '{2'b11,  8, 2'b00, 0, 0, 1, 0, 1, 0};
        tbl[7]  = '{2'b10,  3, 2'b00, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{2'b11, 10, 2'b00, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{2'b00,  4, 2'b00, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{2'b11, 10, 2'b00, 0, 0, 0, 0, 0, 0};

        // Reset with buttons held low: nothing may leak through.
        Reset = 1'b1;
        btn_n = 2'b00;
        model_reset();
        for (int i = 0; i < 4; i++) step();
        check("reset outputs", {btn_level, btn_press, btn_release, btn_long}, 8'h00);
        Reset = 1'b0;

        for (int v = 0; v < 11; v++) begin
            btn_n = tbl[v].btn_n;
            for (int c = 0; c < N; c++) begin
                pc[c] = 0; rc[c] = 0; lc[c] = 0;
            end
            for (int i = 0; i < tbl[v].cycles; i++) begin
                step();
                for (int c = 0; c < N; c++) begin
                    pc[c] += int'(btn_press[c]);
                    rc[c] += int'(btn_release[c]);
                    lc[c] += int'(btn_long[c]);
                end
            end
            check($sformatf("row%0d level", v), {30'd0, btn_level}, {30'd0, tbl[v].exp_level});
            check($sformatf("row%0d press0", v), pc[0], tbl[v].p0);
            check($sformatf("row%0d press1", v), pc[1], tbl[v].p1);
            check($sformatf("row%0d release0", v), rc[0], tbl[v].r0);
            check($sformatf("row%0d release1", v), rc[1], tbl[v].r1);
            check($sformatf("row%0d long0", v), lc[0], tbl[v].l0);
            check($sformatf("row%0d long1", v), lc[1], tbl[v].l1);
        end

        // Press latency, long-press timing and release latency on channel 0.
        btn_n = 2'b10;
        first_a = -1; first_b = -1;
        pc[0] = 0; lc[0] = 0; rc[0] = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (btn_press[0] && first_a < 0) first_a = i;
            if (btn_long[0] && first_b < 0) first_b = i;
            pc[0] += int'(btn_press[0]);
            lc[0] += int'(btn_long[0]);
            rc[0] += int'(btn_release[0]);
        end
        check("press latency", first_a, 7);
        check("long after press", first_b - first_a, LONG_MS);
        check("press count", pc[0], 1);
        check("long count", lc[0], 1);
        check("no release while held", rc[0], 0);
        btn_n = 2'b11;
        first_a = -1; first_b = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (btn_release[0] && first_a < 0) first_a = i;
            if (!btn_level[0] && first_b < 0) first_b = i;
        end
        check("release latency", first_a, 7);
        check("level falls with release", first_b, 7);

        // Bounce every 2 cycles, then a steady press.
        pc[0] = 0;
        for (int i = 0; i < 20; i++) begin
            btn_n = ((i / 2) % 2 == 0) ? 2'b10 : 2'b11;
            step();
            pc[0] += int'(btn_press[0]);
        end
        check("no press during bounce", pc[0], 0);
        btn_n = 2'b10;
        first_a = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (btn_press[0] && first_a < 0) first_a = i;
        end
        check("press after bounce", first_a, 7);
        btn_n = 2'b11;
        for (int i = 0; i < 12; i++) step();

        // Simultaneous press, then release channel 1 only.
        btn_n = 2'b00;
        first_a = -1;
        pvec = '0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (btn_press != 2'b00 && first_a < 0) begin
                first_a = i;
                pvec = btn_press;
            end
        end
        check("simultaneous press cycle", first_a, 7);
        check("simultaneous press vector", {30'd0, pvec}, 32'd3);
        btn_n = 2'b10;
        rc[0] = 0; rc[1] = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            rc[0] += int'(btn_release[0]);
            rc[1] += int'(btn_release[1]);
        end
        check("ch0 not released", rc[0], 0);
        check("ch1 released", rc[1], 1);
        check("levels after ch1 release", {30'd0, btn_level}, 32'd1);

        // Asynchronous reset while channel 0 is held.
        Reset = 1'b1;
        #1;
        model_reset();
        check("async reset outputs", {btn_level, btn_press, btn_release, btn_long}, 8'h00);
        for (int i = 0; i < 3; i++) step();
        Reset = 1'b0;
        first_a = -1; rc[0] = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (btn_press[0] && first_a < 0) first_a = i;
            rc[0] += int'(btn_release[0]);
        end
        check("press after reset", first_a, 7);
        check("no release around reset", rc[0], 0);

        // Randomized run-length stimulus checked cycle by cycle against the model.
        btn_n = 2'b11;
        for (int i = 0; i < 20; i++) step();
        for (int c = 0; c < N; c++) remain[c] = 1;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N; c++) begin
                if (remain[c] == 0) begin
                    btn_n[c] = ~btn_n[c];
                    remain[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 40))
                                                             : int'($urandom_range(1, 7));
                end
                remain[c]--;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
